pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of register-file, HI and LO data fields.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-file write address width.
REQ-003 SHALL have parameter SIDE_W, default 8, meaning width of the opaque side-band payload (load/store op code etc.).
REQ-004 SHALL have parameter CNT_W, default 2, meaning width of the multi-cycle arithmetic step counter.
REQ-005 SHALL have parameter STALL_W, default 6, meaning stall vector width.
REQ-006 SHALL have parameter STAGE, default 3, meaning index of this register in the stall vector; legal range 0..STALL_W-2.
REQ-007 SHALL have parameter PERF_W, default 32, meaning performance counter width.
REQ-008 Ports, clock and reset first:
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_reg_wdata  in  DATA_W  upstream register-file write data.
- in_reg_waddr  in  ADDR_W  upstream write address.
- in_reg_wen  in  1  upstream write enable.
- in_hi_wdata, in_lo_wdata  in  DATA_W each  upstream HI/LO data.
- in_hilo_wen  in  1  upstream HI/LO write enable.
- in_side  in  SIDE_W  upstream side-band payload.
- in_hilo_tmp  in  2*DATA_W  partial multi-cycle product from upstream.
- in_cnt  in  CNT_W  multi-cycle step count from upstream.
- stall  in  STALL_W  per-stage stall vector, 1 = stop.
- flush  in  1  exception/redirect kill of the held instruction.
- out_reg_wdata, out_reg_waddr, out_reg_wen, out_hi_wdata, out_lo_wdata, out_hilo_wen, out_side  out  widths as inputs  registered downstream payload.
- out_valid  out  1  held payload is a real instruction, not a bubble.
- out_hilo_tmp  out  2*DATA_W  partial product fed back upstream.
- out_cnt  out  CNT_W  step count fed back upstream.
- perf_bubbles  out  PERF_W  count of bubbles inserted.
- perf_holds  out  PERF_W  count of hold cycles.

Function
REQ-009 Mode each cycle, priority order: RESET (rst=1), FLUSH (flush=1), BUBBLE (stall[STAGE]=1 and stall[STAGE+1]=0), ADVANCE (stall[STAGE]=0), otherwise HOLD.
REQ-010 ADVANCE SHALL capture every in_* payload field into the matching out_* field on the same edge, set out_valid=1, and clear out_hilo_tmp and out_cnt to 0; latency is exactly 1 cycle.
REQ-011 BUBBLE SHALL load the NOP value: out_reg_waddr=0, out_reg_wen=0, out_reg_wdata=0, out_hi_wdata=0, out_lo_wdata=0, out_hilo_wen=0, out_side=0, out_valid=0.
REQ-012 BUBBLE SHALL capture in_hilo_tmp into out_hilo_tmp and in_cnt into out_cnt, preserving multi-cycle arithmetic progress across the stall.
REQ-013 HOLD SHALL leave all outputs, including out_hilo_tmp and out_cnt, unchanged.
REQ-014 FLUSH SHALL load the NOP value of REQ-011 and clear out_hilo_tmp and out_cnt to 0, regardless of stall.
REQ-015 perf_bubbles SHALL increment by 1 on every BUBBLE cycle; perf_holds SHALL increment by 1 on every HOLD cycle; both wrap from all-ones to 0 without saturating.
REQ-016 FLUSH and RESET cycles SHALL increment neither counter.
REQ-017 Stall bits other than STAGE and STAGE+1 SHALL have no effect.
REQ-018 No combinational path SHALL exist from any input to any output.

Reset
REQ-019 While rst=1 at a rising edge, all outputs SHALL become 0, out_valid=0 and both perf counters 0, overriding flush and stall.
REQ-020 Reset asserted mid-HOLD or mid-multi-cycle sequence SHALL discard held payload and partial product with no residual state.

Verification
REQ-021 Advance: stall=0, in_reg_wdata=0x12345678, in_reg_waddr=5, in_reg_wen=1 -> next cycle same values, out_valid=1, out_cnt=0.
REQ-022 Bubble: stall=6'b001000, in_hilo_tmp=0x00000001_FFFFFFFE, in_cnt=1 -> out_reg_wen=0, out_reg_waddr=0, out_valid=0, out_hilo_tmp=0x00000001_FFFFFFFE, out_cnt=1, perf_bubbles +1.
REQ-023 Hold: load payload 0xA5A5A5A5, then stall=6'b011000 for 3 cycles with changing inputs -> outputs stay 0xA5A5A5A5, perf_holds +3.
REQ-024 Flush priority: flush=1 with stall=6'b011000 and valid payload held -> next cycle out_valid=0, out_hilo_tmp=0, out_cnt=0, counters unchanged.
REQ-025 Reset priority: rst=1 with flush=1 and stall=0 -> all outputs 0; release rst with stall=0 -> first input captured one cycle later.
REQ-026 Counter wrap: PERF_W=4, 16 consecutive BUBBLE cycles -> perf_bubbles returns to 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register with stall/flush handling, bubble insertion and perf counters.
// Multi-cycle arithmetic progress (hilo_tmp, cnt) survives bubbles and is cleared on advance/flush.
module pipe_stage_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int SIDE_W  = 8,
    parameter int CNT_W   = 2,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3,
    parameter int PERF_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_reg_wdata,
    input  logic [ADDR_W-1:0]   in_reg_waddr,
    input  logic                in_reg_wen,
    input  logic [DATA_W-1:0]   in_hi_wdata,
    input  logic [DATA_W-1:0]   in_lo_wdata,
    input  logic                in_hilo_wen,
    input  logic [SIDE_W-1:0]   in_side,
    input  logic [2*DATA_W-1:0] in_hilo_tmp,
    input  logic [CNT_W-1:0]    in_cnt,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    output logic [DATA_W-1:0]   out_reg_wdata,
    output logic [ADDR_W-1:0]   out_reg_waddr,
    output logic                out_reg_wen,
    output logic [DATA_W-1:0]   out_hi_wdata,
    output logic [DATA_W-1:0]   out_lo_wdata,
    output logic                out_hilo_wen,
    output logic [SIDE_W-1:0]   out_side,
    output logic                out_valid,
    output logic [2*DATA_W-1:0] out_hilo_tmp,
    output logic [CNT_W-1:0]    out_cnt,
    output logic [PERF_W-1:0]   perf_bubbles,
    output logic [PERF_W-1:0]   perf_holds
);

    typedef enum logic [1:0] {
        M_FLUSH,
        M_BUBBLE,
        M_ADVANCE,
        M_HOLD
    } mode_t;

    localparam logic [PERF_W-1:0] PERF_ONE = 1;

    mode_t mode;
    logic  stall_here;
    logic  stall_next;
    logic  unused_stall;

    assign stall_here   = stall[STAGE];
    assign stall_next   = stall[STAGE+1];
    // Only this stage and its downstream neighbour matter; the rest of the vector is ignored.
    assign unused_stall = ^stall;

    always_comb begin
        mode = M_HOLD;
        if (flush)
            mode = M_FLUSH;
        else if (stall_here && !stall_next)
            mode = M_BUBBLE;
        else if (!stall_here)
            mode = M_ADVANCE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg_wdata <= '0;
            out_reg_waddr <= '0;
            out_reg_wen   <= 1'b0;
            out_hi_wdata  <= '0;
            out_lo_wdata  <= '0;
            out_hilo_wen  <= 1'b0;
            out_side      <= '0;
            out_valid     <= 1'b0;
            out_hilo_tmp  <= '0;
            out_cnt       <= '0;
            perf_bubbles  <= '0;
            perf_holds    <= '0;
        end else begin
            case (mode)
                M_FLUSH, M_BUBBLE: begin
                    out_reg_wdata <= '0;
                    out_reg_waddr <= '0;
                    out_reg_wen   <= 1'b0;
                    out_hi_wdata  <= '0;
                    out_lo_wdata  <= '0;
                    out_hilo_wen  <= 1'b0;
                    out_side      <= '0;
                    out_valid     <= 1'b0;
                    if (mode == M_BUBBLE) begin
                        // Keep the partial product moving while the stage is stalled.
                        out_hilo_tmp <= in_hilo_tmp;
                        out_cnt      <= in_cnt;
                        perf_bubbles <= perf_bubbles + PERF_ONE;
                    end else begin
                        out_hilo_tmp <= '0;
                        out_cnt      <= '0;
                    end
                end
                M_ADVANCE: begin
                    out_reg_wdata <= in_reg_wdata;
                    out_reg_waddr <= in_reg_waddr;
                    out_reg_wen   <= in_reg_wen;
                    out_hi_wdata  <= in_hi_wdata;
                    out_lo_wdata  <= in_lo_wdata;
                    out_hilo_wen  <= in_hilo_wen;
                    out_side      <= in_side;
                    out_valid     <= 1'b1;
                    out_hilo_tmp  <= '0;
                    out_cnt       <= '0;
                end
                default: begin
                    perf_holds <= perf_holds + PERF_ONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg; perf counters built 4 bits wide so wrap is reachable.
module tb_pipe_stage_reg;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   in_reg_wdata, in_hi_wdata, in_lo_wdata;
    logic [4:0]    in_reg_waddr;
    logic          in_reg_wen, in_hilo_wen;
    logic [7:0]    in_side;
    logic [63:0]   in_hilo_tmp;
    logic [1:0]    in_cnt;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   out_reg_wdata, out_hi_wdata, out_lo_wdata;
    logic [4:0]    out_reg_waddr;
    logic          out_reg_wen, out_hilo_wen, out_valid;
    logic [7:0]    out_side;
    logic [63:0]   out_hilo_tmp;
    logic [1:0]    out_cnt;
    logic [3:0]    perf_bubbles, perf_holds;

    int compared = 0;
    int mismatched = 0;
    logic [3:0] exp_bub = 4'd0;
    logic [3:0] exp_hold = 4'd0;
    logic [111:0] pay;

    pipe_stage_reg #(.PERF_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_reg_wdata(in_reg_wdata), .in_reg_waddr(in_reg_waddr), .in_reg_wen(in_reg_wen),
        .in_hi_wdata(in_hi_wdata), .in_lo_wdata(in_lo_wdata), .in_hilo_wen(in_hilo_wen),
        .in_side(in_side), .in_hilo_tmp(in_hilo_tmp), .in_cnt(in_cnt),
        .stall(stall), .flush(flush),
        .out_reg_wdata(out_reg_wdata), .out_reg_waddr(out_reg_waddr), .out_reg_wen(out_reg_wen),
        .out_hi_wdata(out_hi_wdata), .out_lo_wdata(out_lo_wdata), .out_hilo_wen(out_hilo_wen),
        .out_side(out_side), .out_valid(out_valid), .out_hilo_tmp(out_hilo_tmp),
        .out_cnt(out_cnt), .perf_bubbles(perf_bubbles), .perf_holds(perf_holds)
    );

    always #5 clk = ~clk;

    assign pay = {out_reg_wdata, out_reg_waddr, out_reg_wen, out_hi_wdata, out_lo_wdata,
                  out_hilo_wen, out_side, out_valid};

    function automatic logic [111:0] exp_pay(input logic [31:0] b);
        return {b, b[4:0], 1'b1, ~b, b ^ 32'h0F0F0F0F, 1'b1, b[15:8], 1'b1};
    endfunction

    task automatic load_in(input logic [31:0] b);
        in_reg_wdata = b;
        in_reg_waddr = b[4:0];
        in_reg_wen   = 1'b1;
        in_hi_wdata  = ~b;
        in_lo_wdata  = b ^ 32'h0F0F0F0F;
        in_hilo_wen  = 1'b1;
        in_side      = b[15:8];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b1; stall = 6'b0;
        load_in(32'hDEADBEEF);
        in_hilo_tmp = 64'h1234_5678_9ABC_DEF0; in_cnt = 2'd3;
        step();
        compared++;
        if ({pay, out_hilo_tmp, out_cnt, perf_bubbles, perf_holds} !== '0) begin
            $display("FAIL reset_all_zero: got pay=%h tmp=%h cnt=%0d pb=%0d ph=%0d want all 0",
                     pay, out_hilo_tmp, out_cnt, perf_bubbles, perf_holds);
            mismatched++;
        end
        rst = 1'b0; flush = 1'b0;
        load_in(32'h00000011);
        step();
        compared++;
        if (pay !== exp_pay(32'h00000011)) begin
            $display("FAIL reset_release_capture: got %h want %h", pay, exp_pay(32'h00000011));
            mismatched++;
        end
    endtask

    task automatic test_advance();
        stall = 6'b0;
        load_in(32'h12345678);
        in_reg_waddr = 5'd5;
        in_hilo_tmp = 64'hFFFF_FFFF_FFFF_FFFF; in_cnt = 2'd3;
        step();
        compared++;
        if ({out_reg_wdata, out_reg_waddr, out_reg_wen, out_valid, out_cnt, out_hilo_tmp} !==
            {32'h12345678, 5'd5, 1'b1, 1'b1, 2'd0, 64'd0}) begin
            $display("FAIL advance_basic: got wd=%h wa=%0d we=%b v=%b cnt=%0d tmp=%h want 12345678/5/1/1/0/0",
                     out_reg_wdata, out_reg_waddr, out_reg_wen, out_valid, out_cnt, out_hilo_tmp);
            mismatched++;
        end
        load_in(32'hCAFEF00D);
        step();
        compared++;
        if (pay !== exp_pay(32'hCAFEF00D)) begin
            $display("FAIL advance_full_payload: got %h want %h", pay, exp_pay(32'hCAFEF00D));
            mismatched++;
        end
    endtask

    task automatic test_bubble();
        stall = 6'b001000;
        in_hilo_tmp = 64'h00000001_FFFFFFFE; in_cnt = 2'd1;
        step();
        exp_bub++;
        compared++;
        if ({pay, out_hilo_tmp, out_cnt} !== {112'd0, 64'h00000001_FFFFFFFE, 2'd1}) begin
            $display("FAIL bubble_payload: got pay=%h tmp=%h cnt=%0d want 0/00000001fffffffe/1",
                     pay, out_hilo_tmp, out_cnt);
            mismatched++;
        end
        compared++;
        if ({perf_bubbles, perf_holds} !== {exp_bub, exp_hold}) begin
            $display("FAIL bubble_counters: got pb=%0d ph=%0d want %0d/%0d",
                     perf_bubbles, perf_holds, exp_bub, exp_hold);
            mismatched++;
        end
    endtask

    task automatic test_hold();
        stall = 6'b0;
        load_in(32'hA5A5A5A5);
        step();
        stall = 6'b011000;
        for (int i = 0; i < 3; i++) begin
            load_in(32'h1000 + i * 17);
            in_hilo_tmp = 64'(i + 7); in_cnt = 2'(i + 1);
            step();
            exp_hold++;
            compared++;
            if ({pay, out_cnt} !== {exp_pay(32'hA5A5A5A5), 2'd0}) begin
                $display("FAIL hold_cycle%0d: got pay=%h cnt=%0d want %h/0",
                         i, pay, out_cnt, exp_pay(32'hA5A5A5A5));
                mismatched++;
            end
        end
        compared++;
        if ({perf_holds, perf_bubbles} !== {exp_hold, exp_bub}) begin
            $display("FAIL hold_counters: got ph=%0d pb=%0d want %0d/%0d",
                     perf_holds, perf_bubbles, exp_hold, exp_bub);
            mismatched++;
        end
        stall = 6'b001000;
        in_hilo_tmp = 64'hAAAA_0000_5555_0000; in_cnt = 2'd2;
        step();
        exp_bub++;
        stall = 6'b011000;
        in_hilo_tmp = 64'h1; in_cnt = 2'd0;
        step();
        exp_hold++;
        compared++;
        if ({out_hilo_tmp, out_cnt, perf_holds} !== {64'hAAAA_0000_5555_0000, 2'd2, exp_hold}) begin
            $display("FAIL hold_keeps_partial: got tmp=%h cnt=%0d ph=%0d want aaaa000055550000/2/%0d",
                     out_hilo_tmp, out_cnt, perf_holds, exp_hold);
            mismatched++;
        end
    endtask

    task automatic test_flush();
        stall = 6'b0;
        load_in(32'h000055AA);
        step();
        flush = 1'b1; stall = 6'b011000;
        step();
        compared++;
        if ({pay, perf_bubbles, perf_holds} !== {112'd0, exp_bub, exp_hold}) begin
            $display("FAIL flush_over_hold: got pay=%h pb=%0d ph=%0d want 0/%0d/%0d",
                     pay, perf_bubbles, perf_holds, exp_bub, exp_hold);
            mismatched++;
        end
        flush = 1'b0; stall = 6'b001000;
        in_hilo_tmp = 64'h0000_0003_0000_0009; in_cnt = 2'd3;
        step();
        exp_bub++;
        flush = 1'b1;
        step();
        compared++;
        if ({out_hilo_tmp, out_cnt, out_valid, perf_bubbles} !== {64'd0, 2'd0, 1'b0, exp_bub}) begin
            $display("FAIL flush_over_bubble: got tmp=%h cnt=%0d v=%b pb=%0d want 0/0/0/%0d",
                     out_hilo_tmp, out_cnt, out_valid, perf_bubbles, exp_bub);
            mismatched++;
        end
        flush = 1'b0;
    endtask

    task automatic test_ignored_bits();
        stall = 6'b110111;
        load_in(32'h0BADC0DE);
        step();
        compared++;
        if (pay !== exp_pay(32'h0BADC0DE)) begin
            $display("FAIL other_bits_advance: got %h want %h", pay, exp_pay(32'h0BADC0DE));
            mismatched++;
        end
        stall = 6'b101111;
        step();
        exp_bub++;
        compared++;
        if ({pay, perf_bubbles} !== {112'd0, exp_bub}) begin
            $display("FAIL other_bits_bubble: got pay=%h pb=%0d want 0/%0d", pay, perf_bubbles, exp_bub);
            mismatched++;
        end
        stall = 6'b111111;
        step();
        exp_hold++;
        compared++;
        if ({perf_holds, perf_bubbles} !== {exp_hold, exp_bub}) begin
            $display("FAIL other_bits_hold: got ph=%0d pb=%0d want %0d/%0d",
                     perf_holds, perf_bubbles, exp_hold, exp_bub);
            mismatched++;
        end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_bub = 4'd0; exp_hold = 4'd0;
        stall = 6'b001000;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_bub++;
            if (i == 14 || i == 15) begin
                compared++;
                if (perf_bubbles !== exp_bub) begin
                    $display("FAIL wrap_after_%0d: got %0d want %0d", i + 1, perf_bubbles, exp_bub);
                    mismatched++;
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        stall = 6'b0;
        load_in(32'h77778888);
        step();
        stall = 6'b001000;
        in_hilo_tmp = 64'hDEAD_0000_BEEF_0000; in_cnt = 2'd2;
        step();
        stall = 6'b011000;
        step();
        rst = 1'b1;
        step();
        exp_bub = 4'd0; exp_hold = 4'd0;
        compared++;
        if ({pay, out_hilo_tmp, out_cnt, perf_bubbles, perf_holds} !== '0) begin
            $display("FAIL reset_mid_hold: got pay=%h tmp=%h cnt=%0d pb=%0d ph=%0d want all 0",
                     pay, out_hilo_tmp, out_cnt, perf_bubbles, perf_holds);
            mismatched++;
        end
        rst = 1'b0; stall = 6'b0;
        load_in(32'h31415926);
        step();
        compared++;
        if ({pay, out_hilo_tmp} !== {exp_pay(32'h31415926), 64'd0}) begin
            $display("FAIL reset_mid_recover: got pay=%h tmp=%h want %h/0",
                     pay, out_hilo_tmp, exp_pay(32'h31415926));
            mismatched++;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 6'b0;
        load_in(32'h0); in_hilo_tmp = 64'd0; in_cnt = 2'd0;
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_ignored_bits();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
